spandex_req_responder: RTL and testbench

SPANDEX_REQ_RESPONDER -- requirements
Module: spandex_req_responder

---
 rtl/spandex_req_responder_pkg.sv | 41 ++++
 rtl/spandex_line_merge.sv | 18 +
 rtl/spandex_req_responder.sv | 122 ++++++++++++
 tb/tb_spandex_req_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spandex_req_responder_pkg.sv
// Shared types, message encodings and FSM state for the spandex request responder.
// Lines are WORDS_PER_LINE words; word w occupies bits [w*WORD_BITS +: WORD_BITS].
package spandex_req_responder_pkg;

  localparam int WORD_BITS      = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_BITS      = 16;

  typedef logic [2:0]                            mix_msg_t;
  typedef logic [2:0]                            coh_msg_t;
  typedef logic [ADDR_BITS-1:0]                  line_addr_t;
  typedef logic [WORDS_PER_LINE*WORD_BITS-1:0]   line_t;
  typedef logic [WORDS_PER_LINE-1:0]             word_mask_t;

  localparam mix_msg_t REQ_V  = 3'd0;
  localparam mix_msg_t REQ_O  = 3'd1;
  localparam mix_msg_t REQ_WT = 3'd2;
  localparam mix_msg_t REQ_WB = 3'd3;

  localparam coh_msg_t RSP_V      = 3'd1;
  localparam coh_msg_t RSP_O      = 3'd2;
  localparam coh_msg_t RSP_WT     = 3'd3;
  localparam coh_msg_t RSP_WB_ACK = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RSP} rsp_state_t;

  function automatic logic is_supported(input mix_msg_t m);
    return (m == REQ_V) || (m == REQ_O) || (m == REQ_WT) || (m == REQ_WB);
  endfunction

  function automatic coh_msg_t rsp_of(input mix_msg_t m);
    case (m)
      REQ_V:   return RSP_V;
      REQ_O:   return RSP_O;
      REQ_WT:  return RSP_WT;
      REQ_WB:  return RSP_WB_ACK;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/spandex_line_merge.sv
// Combinational masked word merge: words with mask bit set come from new_line, others from old_line.
module spandex_line_merge
  import spandex_req_responder_pkg::*;
(
  input  line_t      old_line,
  input  line_t      new_line,
  input  word_mask_t mask,
  output line_t      merged_line
);

  always_comb begin
    merged_line = old_line;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (mask[w]) merged_line[w*WORD_BITS +: WORD_BITS] = new_line[w*WORD_BITS +: WORD_BITS];
    end
  end

endmodule

// File: rtl/spandex_req_responder.sv
// Single-outstanding L2 request responder backed by a DEPTH-line memory; response 2+LAT cycles after accept.
// Holds the response until rsp_out_ready and accepts no new request until the response is taken.
module spandex_req_responder
  import spandex_req_responder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LAT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_in_valid,
  output logic       req_in_ready,
  input  mix_msg_t   req_in_coh_msg,
  input  line_addr_t req_in_addr,
  input  line_t      req_in_line,
  input  word_mask_t req_in_word_mask,
  output logic       rsp_out_valid,
  input  logic       rsp_out_ready,
  output coh_msg_t   rsp_out_coh_msg,
  output line_addr_t rsp_out_addr,
  output line_t      rsp_out_line,
  output word_mask_t rsp_out_word_mask,
  output logic [7:0] err_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_state_t state, state_nxt;

  mix_msg_t   req_msg;
  line_addr_t req_addr;
  line_t      req_line;
  word_mask_t req_mask;
  line_t      rd_line;
  logic [3:0] wait_cnt;
  line_t      mem [DEPTH];
  line_t      merged;

  logic [IDX_W-1:0] idx;
  logic             supported;
  logic             is_read;
  logic             is_write;

  // Upper address bits are dropped on purpose, so distinct addresses may alias one line.
  assign idx       = req_addr[IDX_W-1:0];
  assign supported = is_supported(req_msg);
  assign is_read   = (req_msg == REQ_V)  || (req_msg == REQ_O);
  assign is_write  = (req_msg == REQ_WT) || (req_msg == REQ_WB);

  spandex_line_merge u_merge (
    .old_line    (mem[idx]),
    .new_line    (req_line),
    .mask        (req_mask),
    .merged_line (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_in_valid) state_nxt = EXEC;
      EXEC: begin
        if (!supported)   state_nxt = IDLE;
        else if (LAT > 0) state_nxt = WAIT;
        else              state_nxt = RSP;
      end
      WAIT: if (wait_cnt <= 4'd1) state_nxt = RSP;
      RSP:  if (rsp_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_msg  <= '0;
      req_addr <= '0;
      req_line <= '0;
      req_mask <= '0;
      rd_line  <= '0;
      wait_cnt <= '0;
      err_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (req_in_valid && req_in_ready) begin
        req_msg  <= req_in_coh_msg;
        req_addr <= req_in_addr;
        req_line <= req_in_line;
        req_mask <= req_in_word_mask;
      end
      if (state == EXEC) begin
        wait_cnt <= 4'(LAT);
        rd_line  <= is_read ? mem[idx] : '0;
        if (is_write) mem[idx] <= merged;
        if (!supported && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  assign req_in_ready = (state == IDLE);

  always_comb begin
    rsp_out_valid     = 1'b0;
    rsp_out_coh_msg   = '0;
    rsp_out_addr      = '0;
    rsp_out_line      = '0;
    rsp_out_word_mask = '0;
    if (state == RSP) begin
      rsp_out_valid     = 1'b1;
      rsp_out_coh_msg   = rsp_of(req_msg);
      rsp_out_addr      = req_addr;
      rsp_out_line      = rd_line;
      rsp_out_word_mask = req_mask;
    end
  end

endmodule

// File: tb/tb_spandex_req_responder.sv
// Directed bench: a LAT=0 responder checked through a scoreboard, plus a LAT=3 instance for wait and reset-abort.
module tb_spandex_req_responder;
  import spandex_req_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, l_rst = 1'b0;

  logic       req_in_valid = 1'b0, req_in_ready;
  mix_msg_t   req_in_coh_msg = '0;
  line_addr_t req_in_addr = '0;
  line_t      req_in_line = '0;
  word_mask_t req_in_word_mask = '0;
  logic       rsp_out_valid, rsp_out_ready = 1'b0;
  coh_msg_t   rsp_out_coh_msg;
  line_addr_t rsp_out_addr;
  line_t      rsp_out_line;
  word_mask_t rsp_out_word_mask;
  logic [7:0] err_cnt;

  logic       l_req_in_valid = 1'b0, l_req_in_ready;
  mix_msg_t   l_req_in_coh_msg = '0;
  line_addr_t l_req_in_addr = '0;
  line_t      l_req_in_line = '0;
  word_mask_t l_req_in_word_mask = '0;
  logic       l_rsp_out_valid, l_rsp_out_ready = 1'b0;
  coh_msg_t   l_rsp_out_coh_msg;
  line_addr_t l_rsp_out_addr;
  line_t      l_rsp_out_line;
  word_mask_t l_rsp_out_word_mask;
  logic [7:0] l_err_cnt;

  spandex_req_responder #(.DEPTH(16), .LAT(0)) u_dut (
    .clk(clk), .rst(rst),
    .req_in_valid(req_in_valid), .req_in_ready(req_in_ready),
    .req_in_coh_msg(req_in_coh_msg), .req_in_addr(req_in_addr),
    .req_in_line(req_in_line), .req_in_word_mask(req_in_word_mask),
    .rsp_out_valid(rsp_out_valid), .rsp_out_ready(rsp_out_ready),
    .rsp_out_coh_msg(rsp_out_coh_msg), .rsp_out_addr(rsp_out_addr),
    .rsp_out_line(rsp_out_line), .rsp_out_word_mask(rsp_out_word_mask),
    .err_cnt(err_cnt)
  );

  spandex_req_responder #(.DEPTH(16), .LAT(3)) u_lat (
    .clk(clk), .rst(l_rst),
    .req_in_valid(l_req_in_valid), .req_in_ready(l_req_in_ready),
    .req_in_coh_msg(l_req_in_coh_msg), .req_in_addr(l_req_in_addr),
    .req_in_line(l_req_in_line), .req_in_word_mask(l_req_in_word_mask),
    .rsp_out_valid(l_rsp_out_valid), .rsp_out_ready(l_rsp_out_ready),
    .rsp_out_coh_msg(l_rsp_out_coh_msg), .rsp_out_addr(l_rsp_out_addr),
    .rsp_out_line(l_rsp_out_line), .rsp_out_word_mask(l_rsp_out_word_mask),
    .err_cnt(l_err_cnt)
  );

  typedef struct {
    coh_msg_t   msg;
    line_addr_t addr;
    line_t      line;
    word_mask_t mask;
  } exp_t;

  exp_t   exp_q[$];
  line_t  model_mem [16];
  int     err_model = 0;
  int     total = 0;
  int     bad = 0;
  int     rsp_cnt = 0;
  int     l_rsp_cnt = 0;

  always @(posedge clk) if (rsp_out_valid && rsp_out_ready) rsp_cnt++;
  always @(posedge clk) if (l_rsp_out_valid && l_rsp_out_ready) l_rsp_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic line_t mk(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Drive one request from a negedge; returns at the negedge after the handshake edge.
  task automatic send(input mix_msg_t m, input line_addr_t a, input line_t l, input word_mask_t k);
    int n;
    logic [3:0] ix;
    n = 0;
    while (!req_in_ready && n < 50) begin @(negedge clk); n++; end
    chk("send_ready", req_in_ready, 1'b1);
    req_in_valid = 1'b1; req_in_coh_msg = m; req_in_addr = a;
    req_in_line = l; req_in_word_mask = k;
    @(posedge clk);
    @(negedge clk);
    req_in_valid = 1'b0;
    ix = a[3:0];
    case (m)
      REQ_V: exp_q.push_back('{RSP_V, a, model_mem[ix], k});
      REQ_O: exp_q.push_back('{RSP_O, a, model_mem[ix], k});
      REQ_WT, REQ_WB: begin
        for (int w = 0; w < 4; w++)
          if (k[w]) model_mem[ix][w*32 +: 32] = l[w*32 +: 32];
        exp_q.push_back('{(m == REQ_WT) ? RSP_WT : RSP_WB_ACK, a, '0, k});
      end
      default: if (err_model != 255) err_model++;
    endcase
  endtask

  // Wait for a response, compare with the scoreboard head, then accept it.
  task automatic recv(input string tag, output int lat, output line_t got);
    exp_t e;
    lat = 1;
    while (!rsp_out_valid && lat < 50) begin @(negedge clk); lat++; end
    got = rsp_out_line;
    chk({tag, "_valid"}, rsp_out_valid, 1'b1);
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s_sb observed=response expected=none", tag);
    end else if (rsp_out_valid) begin
      e = exp_q.pop_front();
      chk({tag, "_msg"},  rsp_out_coh_msg,   e.msg);
      chk({tag, "_addr"}, rsp_out_addr,      e.addr);
      chk({tag, "_line"}, rsp_out_line,      e.line);
      chk({tag, "_mask"}, rsp_out_word_mask, e.mask);
    end
    rsp_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_out_ready = 1'b0;
  endtask

  task automatic l_xact(input mix_msg_t m, input line_addr_t a, input line_t l, input word_mask_t k,
                        output int lat, output coh_msg_t msg, output line_t got);
    l_req_in_valid = 1'b1; l_req_in_coh_msg = m; l_req_in_addr = a;
    l_req_in_line = l; l_req_in_word_mask = k;
    @(posedge clk);
    @(negedge clk);
    l_req_in_valid = 1'b0;
    lat = 1;
    while (!l_rsp_out_valid && lat < 50) begin @(negedge clk); lat++; end
    msg = l_rsp_out_coh_msg;
    got = l_rsp_out_line;
    l_rsp_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l_rsp_out_ready = 1'b0;
  endtask

  initial begin
    int lat, snap;
    line_t got, hold_line;
    coh_msg_t lmsg;
    line_t la, lb;

    foreach (model_mem[i]) model_mem[i] = '0;
    la = mk(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004);
    lb = mk(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);

    repeat (3) @(negedge clk);
    chk("rst_ready", req_in_ready, 1'b1);
    chk("rst_valid", rsp_out_valid, 1'b0);
    rst = 1'b1; l_rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", req_in_ready, 1'b1);
    chk("reset_valid", rsp_out_valid, 1'b0);
    chk("reset_err", err_cnt, 8'd0);
    chk("reset_rsp_zero", {rsp_out_coh_msg, rsp_out_addr, rsp_out_line, rsp_out_word_mask}, '0);

    // Read after reset returns zero with two-cycle latency.
    send(REQ_V, 16'h0005, '0, 4'hF);
    chk("rd0_exec_novalid", rsp_out_valid, 1'b0);
    recv("rd0", lat, got);
    chk("rd0_latency", lat, 2);
    chk("rd0_line_zero", got, '0);

    // Masked write then read returns the merged line.
    send(REQ_WT, 16'h0003, la, 4'b0101);
    recv("wt3", lat, got);
    send(REQ_O, 16'h0003, '0, 4'hF);
    recv("rdo3", lat, got);
    chk("rdo3_merged", got, mk(32'hAAAA_0001, 32'h0, 32'hCCCC_0003, 32'h0));

    // Aliased write and read.
    send(REQ_WB, 16'h0013, lb, 4'hF);
    recv("wb13", lat, got);
    send(REQ_V, 16'h0003, '0, 4'hF);
    recv("rdv03", lat, got);
    chk("alias_line", got, lb);

    // Backpressure: response held and no request accepted.
    send(REQ_V, 16'h0013, '0, 4'b0011);
    while (!rsp_out_valid) @(negedge clk);
    hold_line = rsp_out_line;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", rsp_out_valid, 1'b1);
      chk("bp_line", rsp_out_line, hold_line);
      chk("bp_addr", rsp_out_addr, 16'h0013);
      chk("bp_ready_low", req_in_ready, 1'b0);
    end
    recv("bp", lat, got);

    // Unsupported opcodes: no response, no write, saturating error count.
    snap = rsp_cnt;
    for (int i = 0; i < 300; i++) send(mix_msg_t'(4 + (i % 4)), 16'h0003, '1, 4'hF);
    repeat (3) @(negedge clk);
    chk("bad_no_rsp", rsp_cnt, snap);
    chk("bad_err_model", err_cnt, err_model);
    chk("bad_err_sat", err_cnt, 8'd255);
    send(REQ_V, 16'h0003, '0, 4'hF);
    recv("bad_mem", lat, got);
    chk("bad_mem_unchanged", got, lb);
    chk("sb_drained", exp_q.size(), 0);

    // LAT=3 instance: latency, then reset mid-WAIT aborts the transaction.
    @(negedge clk);
    chk("lat_ready", l_req_in_ready, 1'b1);
    l_xact(REQ_WB, 16'h0002, la, 4'hF, lat, lmsg, got);
    chk("lat_latency", lat, 5);
    chk("lat_msg", lmsg, RSP_WB_ACK);
    l_xact(REQ_V, 16'h0002, '0, 4'hF, lat, lmsg, got);
    chk("lat_rd_line", got, la);
    chk("lat_rd_msg", lmsg, RSP_V);

    l_req_in_valid = 1'b1; l_req_in_coh_msg = REQ_WT; l_req_in_addr = 16'h0007;
    l_req_in_line = lb; l_req_in_word_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    l_req_in_valid = 1'b0;
    @(negedge clk);
    snap = l_rsp_cnt;
    l_rst = 1'b0;
    #1;
    chk("abort_ready", l_req_in_ready, 1'b1);
    chk("abort_valid", l_rsp_out_valid, 1'b0);
    chk("abort_err", l_err_cnt, 8'd0);
    @(negedge clk);
    l_rst = 1'b1;
    l_rsp_out_ready = 1'b1;
    repeat (10) @(negedge clk);
    l_rsp_out_ready = 1'b0;
    chk("abort_no_rsp", l_rsp_cnt, snap);
    chk("abort_ready_after", l_req_in_ready, 1'b1);
    l_xact(REQ_V, 16'h0007, '0, 4'hF, lat, lmsg, got);
    chk("abort_mem7_zero", got, '0);
    l_xact(REQ_O, 16'h0002, '0, 4'hF, lat, lmsg, got);
    chk("abort_mem2_zero", got, '0);
    chk("abort_rd_lat", lat, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
